// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - execute-to-fetch redirect bundle between the pipeline and branch_redirect_ctrl
// Ports: ex_* instruction fields, breq_i/brlt_i compare flags, fetch_ready_i handshake;
//        redirect_*, flush_o, stall_o, misalign_o and the two event counters back to the pipeline.
// master = pipeline side, slave = controller side.
interface branch_redirect_ctrl_if #(
    parameter int DWIDTH = 32
);
    logic              ex_valid_i;
    logic [6:0]        ex_opcode_i;
    logic [2:0]        ex_funct3_i;
    logic [DWIDTH-1:0] ex_pc_i;
    logic [DWIDTH-1:0] ex_imm_i;
    logic [DWIDTH-1:0] ex_rs1_i;
    logic              breq_i;
    logic              brlt_i;
    logic              fetch_ready_i;
    logic              redirect_valid_o;
    logic [DWIDTH-1:0] redirect_pc_o;
    logic              flush_o;
    logic              stall_o;
    logic              misalign_o;
    logic [31:0]       branch_count_o;
    logic [31:0]       taken_count_o;

    modport master (
        output ex_valid_i, ex_opcode_i, ex_funct3_i, ex_pc_i, ex_imm_i, ex_rs1_i,
               breq_i, brlt_i, fetch_ready_i,
        input  redirect_valid_o, redirect_pc_o, flush_o, stall_o, misalign_o,
               branch_count_o, taken_count_o
    );

    modport slave (
        input  ex_valid_i, ex_opcode_i, ex_funct3_i, ex_pc_i, ex_imm_i, ex_rs1_i,
               breq_i, brlt_i, fetch_ready_i,
        output redirect_valid_o, redirect_pc_o, flush_o, stall_o, misalign_o,
               branch_count_o, taken_count_o
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - resolves branches/jumps in execute and drives the fetch redirect and IF/ID flush
// Ports: clk, reset (synchronous, active-high), bus (branch_redirect_ctrl_if.slave).
module branch_redirect_ctrl #(
    parameter int DWIDTH       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset,
    branch_redirect_ctrl_if.slave bus
);
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] target_q, target_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       branch_cnt_q, branch_cnt_d;
    logic [31:0]       taken_cnt_q, taken_cnt_d;

    logic              is_branch;
    logic              is_jal;
    logic              is_jalr;
    logic              cond_taken;
    logic              taken;
    logic [DWIDTH-1:0] jalr_sum;
    logic [DWIDTH-1:0] target;

    // Instruction decode and target computation; only meaningful while IDLE.
    always_comb begin
        is_branch = (bus.ex_opcode_i == OPCODE_BRANCH);
        is_jal    = (bus.ex_opcode_i == OPCODE_JAL);
        is_jalr   = (bus.ex_opcode_i == OPCODE_JALR);

        // brlt_i already reflects signed/unsigned, so BLT/BLTU and BGE/BGEU share a rule.
        case (bus.ex_funct3_i)
            3'b000:  cond_taken = bus.breq_i;
            3'b001:  cond_taken = ~bus.breq_i;
            3'b100,
            3'b110:  cond_taken = bus.brlt_i;
            3'b101,
            3'b111:  cond_taken = ~bus.brlt_i;
            default: cond_taken = 1'b0;
        endcase

        taken    = (is_branch & cond_taken) | is_jal | is_jalr;
        jalr_sum = bus.ex_rs1_i + bus.ex_imm_i;
        target   = is_jalr ? {jalr_sum[DWIDTH-1:1], 1'b0} : (bus.ex_pc_i + bus.ex_imm_i);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        misalign_d   = misalign_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.ex_valid_i) begin
                    if (is_branch) begin
                        branch_cnt_d = branch_cnt_q + 32'd1;
                    end
                    if (taken) begin
                        taken_cnt_d = taken_cnt_q + 32'd1;
                        // A misaligned target is counted as taken but never sent to fetch.
                        if (target[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end else begin
                            target_d = target;
                            state_d  = REDIRECT;
                        end
                    end
                end
            end
            REDIRECT: begin
                if (bus.fetch_ready_i) begin
                    state_d = FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            target_q     <= '0;
            misalign_q   <= 1'b0;
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            misalign_q   <= misalign_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign bus.redirect_valid_o = (state_q == REDIRECT);
    assign bus.redirect_pc_o    = target_q;
    assign bus.flush_o          = (state_q == FLUSH);
    assign bus.stall_o          = (state_q != IDLE);
    assign bus.misalign_o       = misalign_q;
    assign bus.branch_count_o   = branch_cnt_q;
    assign bus.taken_count_o    = taken_cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;
    localparam int DW = 32;
    localparam int FC = 2;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    branch_redirect_ctrl_if #(.DWIDTH(DW)) bus ();

    branch_redirect_ctrl #(.DWIDTH(DW), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a pending redirect, a count of flush cycles still owed, plus counters.
    bit          m_pending;
    int          m_flush_left;
    logic [31:0] m_pc, m_bc, m_tc;
    bit          m_mis;

    function automatic bit ref_taken(logic [6:0] op, logic [2:0] f3, logic eq, logic lt);
        if (op == OP_JAL || op == OP_JALR) return 1'b1;
        if (op != OP_BR) return 1'b0;
        if (f3 == 3'd0) return eq;
        if (f3 == 3'd1) return !eq;
        if (f3 == 3'd4 || f3 == 3'd6) return lt;
        if (f3 == 3'd5 || f3 == 3'd7) return !lt;
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic [31:0] tgt;
        if (reset) begin
            m_pending = 0; m_flush_left = 0; m_pc = 0; m_mis = 0; m_bc = 0; m_tc = 0;
        end else if (m_pending) begin
            if (bus.fetch_ready_i) begin
                m_pending    = 0;
                m_flush_left = FC;
            end
        end else if (m_flush_left > 0) begin
            m_flush_left = m_flush_left - 1;
        end else if (bus.ex_valid_i) begin
            if (bus.ex_opcode_i == OP_BR) m_bc = m_bc + 1;
            if (ref_taken(bus.ex_opcode_i, bus.ex_funct3_i, bus.breq_i, bus.brlt_i)) begin
                m_tc = m_tc + 1;
                if (bus.ex_opcode_i == OP_JALR) tgt = (bus.ex_rs1_i + bus.ex_imm_i) & ~32'd1;
                else                            tgt = bus.ex_pc_i + bus.ex_imm_i;
                if (tgt % 4 != 0) m_mis = 1;
                else begin
                    m_pending = 1;
                    m_pc      = tgt;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_redirect_valid", 32'(bus.redirect_valid_o), 32'(m_pending));
        chk("m_redirect_pc", bus.redirect_pc_o, m_pc);
        chk("m_flush", 32'(bus.flush_o), 32'(m_flush_left > 0));
        chk("m_stall", 32'(bus.stall_o), 32'(m_pending || m_flush_left > 0));
        chk("m_misalign", 32'(bus.misalign_o), 32'(m_mis));
        chk("m_branch_count", bus.branch_count_o, m_bc);
        chk("m_taken_count", bus.taken_count_o, m_tc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [31:0] rs1,
                             input logic eq, input logic lt);
        bus.ex_valid_i  = 1'b1;
        bus.ex_opcode_i = op;
        bus.ex_funct3_i = f3;
        bus.ex_pc_i     = pc;
        bus.ex_imm_i    = imm;
        bus.ex_rs1_i    = rs1;
        bus.breq_i      = eq;
        bus.brlt_i      = lt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ex_valid_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1;
        logic        eq, lt;
        logic        exp_rv;
        logic [31:0] exp_pc;
        logic        exp_mis;
        logic [31:0] exp_bc, exp_tc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        bus.ex_valid_i = 0; bus.ex_opcode_i = 0; bus.ex_funct3_i = 0; bus.ex_pc_i = 0;
        bus.ex_imm_i = 0; bus.ex_rs1_i = 0; bus.breq_i = 0; bus.brlt_i = 0;
        bus.fetch_ready_i = 1;
        m_pending = 0; m_flush_left = 0; m_pc = 0; m_mis = 0; m_bc = 0; m_tc = 0;

        vecs[0]  = '{OP_BR,   3'd0, 32'h100,      32'h20,       32'h0,   1, 0, 1, 32'h120,  0, 1, 1};
        vecs[1]  = '{OP_BR,   3'd1, 32'h100,      32'h20,       32'h0,   1, 0, 0, 32'h0,    0, 1, 0};
        vecs[2]  = '{OP_BR,   3'd1, 32'h200,      32'hFFFFFFF0, 32'h0,   0, 0, 1, 32'h1F0,  0, 1, 1};
        vecs[3]  = '{OP_BR,   3'd4, 32'h1000,     32'h8,        32'h0,   0, 1, 1, 32'h1008, 0, 1, 1};
        vecs[4]  = '{OP_BR,   3'd5, 32'h1000,     32'h8,        32'h0,   0, 1, 0, 32'h0,    0, 1, 0};
        vecs[5]  = '{OP_BR,   3'd6, 32'h1000,     32'h8,        32'h0,   0, 0, 0, 32'h0,    0, 1, 0};
        vecs[6]  = '{OP_BR,   3'd7, 32'h40,       32'h40,       32'h0,   0, 0, 1, 32'h80,   0, 1, 1};
        vecs[7]  = '{OP_BR,   3'd2, 32'h40,       32'h40,       32'h0,   1, 1, 0, 32'h0,    0, 1, 0};
        vecs[8]  = '{OP_JAL,  3'd0, 32'h300,      32'h100,      32'h0,   0, 0, 1, 32'h400,  0, 0, 1};
        vecs[9]  = '{OP_JALR, 3'd0, 32'h0,        32'h4,        32'h203, 0, 0, 0, 32'h0,    1, 0, 1};
        vecs[10] = '{OP_JALR, 3'd0, 32'h0,        32'h3,        32'h201, 0, 0, 1, 32'h204,  0, 0, 1};
        vecs[11] = '{OP_ALU,  3'd0, 32'h100,      32'h20,       32'h0,   1, 1, 0, 32'h0,    0, 0, 0};
        vecs[12] = '{OP_BR,   3'd0, 32'h100,      32'h2,        32'h0,   1, 0, 0, 32'h0,    1, 1, 1};
        vecs[13] = '{OP_JAL,  3'd0, 32'hFFFFFFF0, 32'h20,       32'h0,   0, 0, 1, 32'h10,   0, 0, 1};

        // Reset state
        do_reset();
        chk("reset_redirect_valid", 32'(bus.redirect_valid_o), 32'd0);
        chk("reset_redirect_pc", bus.redirect_pc_o, 32'd0);
        chk("reset_flush", 32'(bus.flush_o), 32'd0);
        chk("reset_stall", 32'(bus.stall_o), 32'd0);
        chk("reset_counts", bus.branch_count_o | bus.taken_count_o, 32'd0);

        // Table: one instruction from reset, outputs one cycle after acceptance
        for (int i = 0; i < 14; i++) begin
            do_reset();
            bus.fetch_ready_i = 1'b1;
            set_instr(vecs[i].op, vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].eq, vecs[i].lt);
            tick();
            bus.ex_valid_i = 1'b0;
            chk($sformatf("vec%0d_redirect_valid", i), 32'(bus.redirect_valid_o), 32'(vecs[i].exp_rv));
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) chk($sformatf("vec%0d_redirect_pc", i), bus.redirect_pc_o, vecs[i].exp_pc);
            chk($sformatf("vec%0d_misalign", i), 32'(bus.misalign_o), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d_branch_count", i), bus.branch_count_o, vecs[i].exp_bc);
            chk($sformatf("vec%0d_taken_count", i), bus.taken_count_o, vecs[i].exp_tc);
            for (int k = 0; k < FC + 2; k++) tick();
        end

        // BEQ redirect then flush for exactly FC cycles
        do_reset();
        set_instr(OP_BR, 3'd0, 32'h100, 32'h20, 32'h0, 1, 0);
        tick();
        bus.ex_valid_i = 1'b0;
        chk("beq_redirect_pc", bus.redirect_pc_o, 32'h120);
        begin
            int flush_seen = 0;
            for (int k = 0; k < FC + 3; k++) begin
                tick();
                if (bus.flush_o) flush_seen++;
            end
            chk("beq_flush_cycles", 32'(flush_seen), 32'(FC));
        end
        chk("beq_counts", {bus.branch_count_o[15:0], bus.taken_count_o[15:0]}, 32'h0001_0001);

        // Sticky misalign then aligned JALR
        do_reset();
        set_instr(OP_JALR, 3'd0, 32'h0, 32'h4, 32'h203, 0, 0);
        tick();
        chk("jalr_mis_norv", 32'(bus.redirect_valid_o), 32'd0);
        set_instr(OP_JALR, 3'd0, 32'h0, 32'h3, 32'h201, 0, 0);
        tick();
        bus.ex_valid_i = 1'b0;
        chk("jalr_ok_pc", bus.redirect_pc_o, 32'h204);
        chk("jalr_mis_sticky", 32'(bus.misalign_o), 32'd1);
        chk("jalr_taken", bus.taken_count_o, 32'd2);
        for (int k = 0; k < FC + 2; k++) tick();

        // Back-pressure: ready low 3 cycles, extra ex_valid ignored
        do_reset();
        bus.fetch_ready_i = 1'b0;
        set_instr(OP_BR, 3'd0, 32'h500, 32'h40, 32'h0, 1, 0);
        tick();
        set_instr(OP_JAL, 3'd0, 32'h800, 32'h100, 32'h0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d_valid", k), 32'(bus.redirect_valid_o), 32'd1);
            chk($sformatf("bp%0d_pc", k), bus.redirect_pc_o, 32'h540);
            chk($sformatf("bp%0d_taken", k), bus.taken_count_o, 32'd1);
            if (k == 3) bus.fetch_ready_i = 1'b1;
            tick();
        end
        bus.ex_valid_i = 1'b0;
        chk("bp_flush", 32'(bus.flush_o), 32'd1);
        chk("bp_branch", bus.branch_count_o, 32'd1);
        for (int k = 0; k < FC + 2; k++) tick();

        // Reset in the first flush cycle
        do_reset();
        set_instr(OP_BR, 3'd0, 32'h100, 32'h20, 32'h0, 1, 0);
        tick();
        bus.ex_valid_i = 1'b0;
        tick();
        chk("rf_flush_before", 32'(bus.flush_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rf_outputs", {29'd0, bus.redirect_valid_o, bus.flush_o, bus.stall_o}, 32'd0);
        chk("rf_pc", bus.redirect_pc_o, 32'd0);
        chk("rf_counts", bus.branch_count_o | bus.taken_count_o, 32'd0);
        tick();
        chk("rf_idle", 32'(bus.stall_o), 32'd0);

        // taken_count wrap
        do_reset();
        force dut.taken_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.taken_cnt_q;
        m_tc = 32'hFFFF_FFFF;
        set_instr(OP_JAL, 3'd0, 32'h0, 32'h8, 32'h0, 0, 0);
        tick();
        bus.ex_valid_i = 1'b0;
        chk("wrap_taken", bus.taken_count_o, 32'd0);
        for (int k = 0; k < FC + 2; k++) tick();

        // Random stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            reset = ($urandom_range(0, 99) == 0);
            sel = $urandom_range(0, 3);
            bus.ex_valid_i  = $urandom_range(0, 1);
            bus.ex_opcode_i = (sel == 0) ? OP_BR : (sel == 1) ? OP_JAL : (sel == 2) ? OP_JALR : OP_ALU;
            bus.ex_funct3_i = 3'($urandom_range(0, 7));
            bus.ex_pc_i     = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'd3);
            bus.ex_imm_i    = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'd3);
            bus.ex_rs1_i    = $urandom;
            bus.breq_i      = 1'($urandom_range(0, 1));
            bus.brlt_i      = 1'($urandom_range(0, 1));
            bus.fetch_ready_i = ($urandom_range(0, 9) < 7);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
